// File: rtl/core_defs.sv
// Shared definitions for the tile rotation buffer: geometry, rotation codes,
// controller states and the direction-to-clockwise rotation helper.
package core_defs;

  localparam int P_TILE_DIM = 8;
  localparam int P_BPP      = 3;
  localparam int P_WORDS    = 48;

  localparam logic [1:0] P_DEG_0   = 2'd0;
  localparam logic [1:0] P_DEG_90  = 2'd1;
  localparam logic [1:0] P_DEG_180 = 2'd2;
  localparam logic [1:0] P_DEG_270 = 2'd3;

  typedef enum logic {
    P_FILL  = 1'b0,
    P_DRAIN = 1'b1
  } state_t;

  // Counter-clockwise by d is clockwise by (4-d) mod 4, which 2-bit wrap gives.
  function automatic logic [1:0] eff_rot(input logic [1:0] deg, input logic dir);
    return dir ? deg : (2'd0 - deg);
  endfunction

endpackage

// File: rtl/core_rot_map.sv
// Maps an output pixel index of the rotated tile to the input pixel it comes
// from, for a clockwise rotation of 0/90/180/270 degrees.
module core_rot_map
  import core_defs::*;
(
  input  logic [1:0] rot,
  input  logic [5:0] out_idx,
  output logic [5:0] src_idx
);

  logic [2:0] row;
  logic [2:0] col;

  assign row = out_idx[5:3];
  assign col = out_idx[2:0];

  always_comb begin
    src_idx = out_idx;
    case (rot)
      P_DEG_0:   src_idx = {row, col};
      P_DEG_90:  src_idx = {3'd7 - col, row};
      P_DEG_180: src_idx = {3'd7 - row, 3'd7 - col};
      P_DEG_270: src_idx = {col, 3'd7 - row};
      default:   src_idx = out_idx;
    endcase
  end

endmodule

// File: rtl/core_tile_buf.sv
// Single 8x8 RGB888 tile buffer: fills 48 words, then drains the same tile
// rotated by the rotation latched with the first fill word.
module core_tile_buf #(
  parameter int P_TILE_DIM = core_defs::P_TILE_DIM,
  parameter int P_BPP      = core_defs::P_BPP,
  parameter int P_WORDS    = core_defs::P_WORDS
) (
  input  logic        I_TB_HCLK,
  input  logic        I_TB_HRESET,
  input  logic [1:0]  I_TB_DEGREES,
  input  logic        I_TB_DIRECTION,
  input  logic        I_TB_CLEAR,
  input  logic [31:0] I_TB_WDATA,
  input  logic        I_TB_WVALID,
  output logic        O_TB_WREADY,
  output logic [31:0] O_TB_RDATA,
  output logic        O_TB_RVALID,
  input  logic        I_TB_RREADY,
  output logic        O_TB_BUSY,
  output logic        O_TB_TILE_DONE
);
  import core_defs::*;

  localparam int         TILE_BYTES = P_TILE_DIM * P_TILE_DIM * P_BPP;
  localparam logic [5:0] LAST_WORD  = 6'(P_WORDS - 1);

  state_t      state, next_state;
  logic [5:0]  cnt, next_cnt;
  logic [1:0]  rot;
  logic        done, next_done;
  logic        fill_fire;
  logic [7:0]  tile [TILE_BYTES];
  logic [7:0]  wr_base;
  logic [31:0] word;

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_done  = 1'b0;
    fill_fire  = 1'b0;
    if (state == P_FILL) begin
      if (I_TB_WVALID) begin
        fill_fire = 1'b1;
        if (cnt == LAST_WORD) begin
          next_state = P_DRAIN;
          next_cnt   = 6'd0;
        end else begin
          next_cnt = cnt + 6'd1;
        end
      end
    end else begin
      if (I_TB_RREADY) begin
        if (cnt == LAST_WORD) begin
          next_state = P_FILL;
          next_cnt   = 6'd0;
          next_done  = 1'b1;
        end else begin
          next_cnt = cnt + 6'd1;
        end
      end
    end
    // Abort wins over any handshake in the same cycle; that handshake is dropped.
    if (I_TB_CLEAR) begin
      next_state = P_FILL;
      next_cnt   = 6'd0;
      next_done  = 1'b0;
      fill_fire  = 1'b0;
    end
  end

  always_ff @(posedge I_TB_HCLK or posedge I_TB_HRESET) begin
    if (I_TB_HRESET) begin
      state <= P_FILL;
      cnt   <= 6'd0;
      rot   <= P_DEG_0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      done  <= next_done;
      if (fill_fire && cnt == 6'd0)
        rot <= eff_rot(I_TB_DEGREES, I_TB_DIRECTION);
    end
  end

  assign wr_base = {cnt, 2'b00};

  // Storage is intentionally not reset; every byte is rewritten before a drain.
  always_ff @(posedge I_TB_HCLK) begin
    if (fill_fire) begin
      for (int j = 0; j < 4; j++)
        tile[wr_base + 8'(j)] <= I_TB_WDATA[8*j +: 8];
    end
  end

  // Each output byte lane finds its pixel/component, then reads the source byte.
  for (genvar j = 0; j < 4; j++) begin : g_lane
    logic [7:0] byte_idx;
    logic [5:0] out_pix;
    logic [5:0] src_pix;
    logic [1:0] comp;
    logic [7:0] src_byte;

    assign byte_idx = wr_base + 8'(j);
    assign out_pix  = 6'(byte_idx / 8'd3);
    assign comp     = 2'(byte_idx % 8'd3);

    core_rot_map u_map (
      .rot     (rot),
      .out_idx (out_pix),
      .src_idx (src_pix)
    );

    assign src_byte       = 8'(src_pix) * 8'd3 + 8'(comp);
    assign word[8*j +: 8] = tile[src_byte];
  end

  assign O_TB_WREADY    = (state == P_FILL);
  assign O_TB_RVALID    = (state == P_DRAIN);
  assign O_TB_RDATA     = (state == P_DRAIN) ? word : 32'd0;
  assign O_TB_BUSY      = (state == P_DRAIN) || (cnt != 6'd0);
  assign O_TB_TILE_DONE = done;

endmodule

// File: tb/tb_core_tile_buf.sv
// Scoreboard bench: fill stimulus pushes expected rotated words, a negedge
// monitor pops and compares every accepted drain word.
module tb_core_tile_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  deg;
  logic        dir;
  logic        clear;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic        busy;
  logic        tile_done;

  core_tile_buf dut (
    .I_TB_HCLK      (clk),
    .I_TB_HRESET    (rst),
    .I_TB_DEGREES   (deg),
    .I_TB_DIRECTION (dir),
    .I_TB_CLEAR     (clear),
    .I_TB_WDATA     (wdata),
    .I_TB_WVALID    (wvalid),
    .O_TB_WREADY    (wready),
    .O_TB_RDATA     (rdata),
    .O_TB_RVALID    (rvalid),
    .I_TB_RREADY    (rready),
    .O_TB_BUSY      (busy),
    .O_TB_TILE_DONE (tile_done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  int          done_seen = 0;
  int          drain_idx = 0;
  logic [31:0] first_word = 32'd0;
  logic        hold_valid = 1'b0;
  logic [31:0] hold_data = 32'd0;
  logic        prev_done = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Input image: pixel n has R=n, G=n+0x40, B=n+0x80.
  function automatic logic [31:0] fillWord(input int k);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      int b;
      b = 4*k + j;
      w[8*j +: 8] = 8'((b / 3) + 64 * (b % 3));
    end
    return w;
  endfunction

  // Expected output: walk the source coordinate back through cw quarter turns.
  function automatic logic [31:0] expWord(input int cw, input int k);
    logic [31:0] w;
    w = 32'd0;
    for (int j = 0; j < 4; j++) begin
      int b, p, sr, sc, t;
      b  = 4*k + j;
      p  = b / 3;
      sr = p / 8;
      sc = p % 8;
      for (int q = 0; q < cw; q++) begin
        t  = sr;
        sr = 7 - sc;
        sc = t;
      end
      w[8*j +: 8] = 8'(8*sr + sc + 64 * (b % 3));
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      hold_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (tile_done) begin
        done_seen++;
        checkOutput("done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = tile_done;
      if (rvalid) begin
        checkOutput("wready_in_drain", 32'(wready), 32'd0);
        if (hold_valid) checkOutput("rdata_stable", rdata, hold_data);
        if (rready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_drain_word actual=%h required=none", rdata);
          end else begin
            checkOutput($sformatf("drain_word%0d", drain_idx), rdata, exp_q.pop_front());
          end
          if (drain_idx == 0) first_word = rdata;
          drain_idx++;
          hold_valid = 1'b0;
        end else begin
          hold_valid = 1'b1;
          hold_data  = rdata;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  // Fill 'upto' words; rotation inputs are scrambled after word 0 to prove latching.
  task automatic applyStimulus(input logic [1:0] d, input logic r, input int upto, input bit gaps);
    int cw;
    cw = r ? int'(d) : (4 - int'(d)) % 4;
    if (upto == 48)
      for (int k = 0; k < 48; k++) exp_q.push_back(expWord(cw, k));
    for (int k = 0; k < upto; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          wvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      deg    = (k == 0) ? d : ~d;
      dir    = (k == 0) ? r : ~r;
      wdata  = fillWord(k);
      wvalid = 1'b1;
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
  endtask

  task automatic drainTile(input bit gaps, input int upto);
    int accepted;
    int cycles;
    accepted = 0;
    cycles   = 0;
    while (accepted < upto && cycles < 1000) begin
      rready = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rvalid && rready) accepted++;
      @(posedge clk); #1;
      cycles++;
    end
    rready = 1'b0;
    if (accepted < upto) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d required=%0d", accepted, upto);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wready"}, 32'(wready), 32'd1);
    checkOutput({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(tile_done), 32'd0);
  endtask

  task automatic runTile(input logic [1:0] d, input logic r, input bit gaps,
                         input logic [31:0] w0, input string name);
    int d0;
    d0 = done_seen;
    drain_idx = 0;
    applyStimulus(d, r, 48, gaps);
    drainTile(gaps, 48);
    @(posedge clk); #1;
    checkOutput({name, "_done_count"}, 32'(done_seen - d0), 32'd1);
    checkOutput({name, "_word0"}, first_word, w0);
    checkOutput({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    rst    = 1'b1;
    clear  = 1'b0;
    wvalid = 1'b0;
    rready = 1'b0;
    wdata  = 32'd0;
    deg    = 2'd0;
    dir    = 1'b1;
    #1;
    checkReset("reset_active");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkReset("reset_released");

    runTile(2'd0, 1'b1, 1'b0, 32'h01804000, "rot0_cw");
    runTile(2'd1, 1'b1, 1'b0, 32'h30B87838, "rot90_cw");
    runTile(2'd3, 1'b0, 1'b0, 32'h30B87838, "rot270_ccw");
    runTile(2'd2, 1'b0, 1'b0, 32'h3EBF7F3F, "rot180_ccw");
    runTile(2'd3, 1'b1, 1'b0, 32'h0F874707, "rot270_cw");
    runTile(2'd1, 1'b1, 1'b1, 32'h30B87838, "rot90_gaps");

    // Abort after fill word 20, with a colliding fill handshake in the clear cycle.
    d0 = done_seen;
    applyStimulus(2'd1, 1'b1, 21, 1'b0);
    checkOutput("clear_busy_before", 32'(busy), 32'd1);
    clear  = 1'b1;
    wvalid = 1'b1;
    wdata  = fillWord(21);
    @(posedge clk); #1;
    clear  = 1'b0;
    wvalid = 1'b0;
    checkOutput("clear_busy_after", 32'(busy), 32'd0);
    checkOutput("clear_wready", 32'(wready), 32'd1);
    checkOutput("clear_rvalid", 32'(rvalid), 32'd0);
    @(posedge clk); #1;
    checkOutput("clear_no_done", 32'(done_seen - d0), 32'd0);
    runTile(2'd0, 1'b1, 1'b0, 32'h01804000, "after_clear");

    // Asynchronous reset after ten drain words.
    d0 = done_seen;
    drain_idx = 0;
    applyStimulus(2'd2, 1'b1, 48, 1'b0);
    drainTile(1'b0, 10);
    checkOutput("mid_drain_busy", 32'(busy), 32'd1);
    checkOutput("mid_drain_count", 32'(drain_idx), 32'd10);
    rst = 1'b1;
    #1;
    checkReset("reset_mid_drain");
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkReset("reset_mid_drain_after");
    checkOutput("reset_no_done", 32'(done_seen - d0), 32'd0);
    runTile(2'd2, 1'b1, 1'b0, 32'h3EBF7F3F, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
